// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage controller between execute and the data memory.
// Accepts one load/store at a time, bounds-checks it, drives the memory port,
// extends load data and returns a tagged response to writeback.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [5:0]  reqAddr,
  input  logic [31:0] reqData,
  input  logic [2:0]  reqType,
  input  logic [4:0]  reqRd,
  output logic        memWrite,
  output logic [5:0]  memAddr,
  output logic [31:0] memDataIn,
  output logic [2:0]  memType,
  input  logic [31:0] memDataOut,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic [4:0]  rspRd,
  output logic        rspError
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } state_e;

  localparam logic [6:0] LIMIT = 7'(MEM_BYTES);

  state_e      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;

  logic [2:0]  size_m1;
  logic [6:0]  last_byte;
  logic        req_err;
  logic [31:0] load_ext;

  // Classify the incoming request: illegal type, unsigned store, or any byte past the end.
  always_comb begin
    size_m1 = 3'd0;
    case (reqType)
      3'd0:       size_m1 = 3'd3;
      3'd1, 3'd2: size_m1 = 3'd1;
      default:    size_m1 = 3'd0;
    endcase
    last_byte = {1'b0, reqAddr} + {4'b0, size_m1};
    req_err   = (reqType > 3'd4)
              || (reqWrite && ((reqType == 3'd2) || (reqType == 3'd4)))
              || (last_byte >= LIMIT);
  end

  // Sign/zero extension of the registered memory read data by the latched type.
  always_comb begin
    load_ext = memDataOut;
    case (type_q)
      3'd1:    load_ext = {{16{memDataOut[15]}}, memDataOut[15:0]};
      3'd2:    load_ext = {16'h0000, memDataOut[15:0]};
      3'd3:    load_ext = {{24{memDataOut[7]}}, memDataOut[7:0]};
      3'd4:    load_ext = {24'h000000, memDataOut[7:0]};
      default: load_ext = memDataOut;
    endcase
  end

  // Next-state and datapath-register update.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    type_d     = type_q;
    rsp_data_d = rsp_data_q;
    rd_d       = rd_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          addr_d     = reqAddr;
          data_d     = reqData;
          type_d     = reqType;
          rd_d       = reqRd;
          err_d      = req_err;
          rsp_data_d = '0;
          if (req_err) begin
            state_d = RESP;
          end else if (reqWrite) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d = load_ext;
        state_d    = RESP;
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rspReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request/response registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      type_q     <= '0;
      rsp_data_q <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      type_q     <= type_d;
      rsp_data_q <= rsp_data_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  // Memory port: real type only while reading or writing, harmless word reads otherwise.
  always_comb begin
    memType = 3'd0;
    if ((state_q == READ) || (state_q == WRITE)) begin
      case (type_q)
        3'd1, 3'd2: memType = 3'd1;
        3'd3, 3'd4: memType = 3'd3;
        default:    memType = 3'd0;
      endcase
    end
  end

  // memWrite decodes the state register directly so reset drops it without a clock edge.
  assign memWrite  = (state_q == WRITE);
  assign memAddr   = addr_q;
  assign memDataIn = data_q;

  assign reqReady  = rstn && (state_q == IDLE);
  assign rspValid  = (state_q == RESP);
  assign rspData   = rsp_data_q;
  assign rspRd     = rd_q;
  assign rspError  = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit against a
// byte-array reference model, with a simple registered-read memory attached.
module tb_mem_access_unit;

  localparam int MEMB = 32;

  logic        clk = 1'b0;
  logic        rstn;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [5:0]  reqAddr;
  logic [31:0] reqData;
  logic [2:0]  reqType;
  logic [4:0]  reqRd;
  logic        memWrite;
  logic [5:0]  memAddr;
  logic [31:0] memDataIn;
  logic [2:0]  memType;
  logic [31:0] memDataOut;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspData;
  logic [4:0]  rspRd;
  logic        rspError;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.MEM_BYTES(MEMB)) dut (
    .clk(clk), .rstn(rstn),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqData(reqData), .reqType(reqType), .reqRd(reqRd),
    .memWrite(memWrite), .memAddr(memAddr), .memDataIn(memDataIn),
    .memType(memType), .memDataOut(memDataOut),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .rspRd(rspRd), .rspError(rspError)
  );

  always #5 clk = ~clk;

  // Attached data memory: little-endian bytes, registered read, no extension.
  logic [7:0] smem [0:71];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 72; i++) smem[i] <= 8'((i * 37 + 11) & 255);
      mem_init <= 1'b1;
    end else begin
      case (memType)
        3'd1:    memDataOut <= {16'h0000, smem[{1'b0, memAddr} + 7'd1], smem[{1'b0, memAddr}]};
        3'd3:    memDataOut <= {24'h000000, smem[{1'b0, memAddr}]};
        default: memDataOut <= {smem[{1'b0, memAddr} + 7'd3], smem[{1'b0, memAddr} + 7'd2],
                                smem[{1'b0, memAddr} + 7'd1], smem[{1'b0, memAddr}]};
      endcase
      if (memWrite) begin
        smem[{1'b0, memAddr}] <= memDataIn[7:0];
        if (memType != 3'd3) smem[{1'b0, memAddr} + 7'd1] <= memDataIn[15:8];
        if (memType == 3'd0) begin
          smem[{1'b0, memAddr} + 7'd2] <= memDataIn[23:16];
          smem[{1'b0, memAddr} + 7'd3] <= memDataIn[31:24];
        end
      end
    end
  end

  // Reference model: byte array plus arithmetic rules for size, legality and extension.
  int rmem [0:63];

  function automatic int ref_size(input int t);
    if (t == 0) return 4;
    if (t <= 2) return 2;
    return 1;
  endfunction

  function automatic bit ref_err(input bit w, input int a, input int t);
    if (t > 4) return 1'b1;
    if (w && (t == 2 || t == 4)) return 1'b1;
    return (a + ref_size(t) - 1) >= MEMB;
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int t);
    longint v = 0;
    longint scale = 1;
    logic [63:0] bits;
    for (int i = 0; i < ref_size(t); i++) begin
      v = v + rmem[a + i] * scale;
      scale = scale * 256;
    end
    if (t == 1 && v >= 32768) v = v - 65536;
    if (t == 3 && v >= 128) v = v - 256;
    bits = 64'(v);
    return bits[31:0];
  endfunction

  function automatic void ref_store(input int a, input logic [31:0] d, input int t);
    longint v = longint'(d);
    for (int i = 0; i < ref_size(t); i++) begin
      rmem[a + i] = int'(v % 256);
      v = v / 256;
    end
  endfunction

  function automatic int ref_lat(input bit e, input bit w);
    if (e) return 1;
    return w ? 2 : 3;
  endfunction

  // Issues one request, waits (bounded) for the response; completes the handshake unless hold.
  task automatic do_req(input logic w, input logic [5:0] a, input logic [31:0] d,
                        input logic [2:0] t, input logic [4:0] rd, input bit hold,
                        output logic [31:0] odata, output logic oerr, output logic [4:0] ord,
                        output int lat, output int wcnt);
    int guard;
    odata = 'x; oerr = 1'bx; ord = 'x; lat = -1; wcnt = 0;
    rspReady = !hold;
    reqWrite = w; reqAddr = a; reqData = d; reqType = t; reqRd = rd;
    reqValid = 1'b1;
    @(negedge clk);
    guard = 0;
    while (reqReady !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (reqReady !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept_timeout: reqReady=%b required 1 within 20 cycles", reqReady);
      reqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqWrite = 1'($urandom); reqAddr = 6'($urandom); reqData = $urandom;
    reqType = 3'($urandom); reqRd = 5'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (memWrite === 1'b1) wcnt++;
    end while (rspValid !== 1'b1 && lat < 20);
    if (rspValid !== 1'b1) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: rspValid=%b required 1 within 20 cycles", rspValid);
      lat = -1;
      return;
    end
    odata = rspData; oerr = rspError; ord = rspRd;
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0;
    reqType = '0; reqRd = '0; rspReady = 1'b1;
    #12;
    tests++;
    if (reqReady !== 1'b0) begin
      fails++; $display("FAIL reset_reqready: got %b required 0", reqReady);
    end
    tests++;
    if ({memWrite, memAddr, memDataIn, memType, rspValid, rspData, rspRd, rspError} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: memWrite=%b memAddr=%h memDataIn=%h memType=%h rspValid=%b rspData=%h rspRd=%h rspError=%b required all 0",
               memWrite, memAddr, memDataIn, memType, rspValid, rspData, rspRd, rspError);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if (reqReady !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b required 1", reqReady);
    end
  endtask

  task automatic test_word_store_load();
    logic [31:0] d; logic e; logic [4:0] r; int lat, wc;
    do_req(1'b1, 6'd4, 32'h8899AABB, 3'd0, 5'd3, 1'b0, d, e, r, lat, wc);
    ref_store(4, 32'h8899AABB, 0);
    tests++;
    if (wc !== 1 || e !== 1'b0 || lat !== 2 || d !== 32'h0 || r !== 5'd3) begin
      fails++;
      $display("FAIL word_store: wcnt=%0d err=%b lat=%0d data=%h rd=%0d required 1 0 2 00000000 3", wc, e, lat, d, r);
    end
    do_req(1'b0, 6'd4, 32'h0, 3'd0, 5'd17, 1'b0, d, e, r, lat, wc);
    tests++;
    if (d !== 32'h8899AABB || e !== 1'b0 || r !== 5'd17) begin
      fails++; $display("FAIL word_load_data: data=%h err=%b rd=%0d required 8899aabb 0 17", d, e, r);
    end
    tests++;
    if (lat !== 3 || wc !== 0) begin
      fails++; $display("FAIL word_load_latency: lat=%0d wcnt=%0d required 3 0", lat, wc);
    end
  endtask

  task automatic test_extension();
    logic [31:0] d; logic e; logic [4:0] r; int lat, wc;
    logic [31:0] want [1:4];
    want[1] = 32'hFFFFF080; want[2] = 32'h0000F080; want[3] = 32'hFFFFFF80; want[4] = 32'h00000080;
    do_req(1'b1, 6'd8, 32'h12345680, 3'd3, 5'd1, 1'b0, d, e, r, lat, wc);
    ref_store(8, 32'h12345680, 3);
    do_req(1'b1, 6'd9, 32'hAB00CDF0, 3'd3, 5'd2, 1'b0, d, e, r, lat, wc);
    ref_store(9, 32'hAB00CDF0, 3);
    for (int t = 1; t <= 4; t++) begin
      do_req(1'b0, 6'd8, 32'h0, 3'(t), 5'(t + 8), 1'b0, d, e, r, lat, wc);
      tests++;
      if (d !== want[t] || d !== ref_load(8, t) || e !== 1'b0 || lat !== 3) begin
        fails++;
        $display("FAIL extend_type%0d: data=%h err=%b lat=%0d required %h 0 3", t, d, e, lat, want[t]);
      end
    end
  endtask

  task automatic test_bounds();
    logic [31:0] d; logic e; logic [4:0] r; int lat, wc;
    do_req(1'b0, 6'd28, 32'h0, 3'd0, 5'd5, 1'b0, d, e, r, lat, wc);
    tests++;
    if (e !== 1'b0 || d !== ref_load(28, 0) || lat !== 3) begin
      fails++; $display("FAIL bound_word28: err=%b data=%h lat=%0d required 0 %h 3", e, d, lat, ref_load(28, 0));
    end
    do_req(1'b0, 6'd29, 32'h0, 3'd0, 5'd6, 1'b0, d, e, r, lat, wc);
    tests++;
    if (e !== 1'b1 || d !== 32'h0 || wc !== 0 || lat !== 1) begin
      fails++; $display("FAIL bound_word29: err=%b data=%h wcnt=%0d lat=%0d required 1 0 0 1", e, d, wc, lat);
    end
    do_req(1'b1, 6'd31, 32'hCAFEF00D, 3'd1, 5'd7, 1'b0, d, e, r, lat, wc);
    tests++;
    if (e !== 1'b1 || wc !== 0 || d !== 32'h0 || r !== 5'd7) begin
      fails++; $display("FAIL bound_half_store31: err=%b wcnt=%0d data=%h rd=%0d required 1 0 0 7", e, wc, d, r);
    end
    do_req(1'b0, 6'd31, 32'h0, 3'd4, 5'd8, 1'b0, d, e, r, lat, wc);
    tests++;
    if (e !== 1'b0 || d !== ref_load(31, 4)) begin
      fails++; $display("FAIL bound_byte31: err=%b data=%h required 0 %h", e, d, ref_load(31, 4));
    end
    do_req(1'b0, 6'd40, 32'h0, 3'd3, 5'd9, 1'b0, d, e, r, lat, wc);
    tests++;
    if (e !== 1'b1 || d !== 32'h0 || lat !== 1) begin
      fails++; $display("FAIL bound_byte40: err=%b data=%h lat=%0d required 1 0 1", e, d, lat);
    end
  endtask

  task automatic test_illegal_types();
    logic [31:0] d; logic e; logic [4:0] r; int lat, wc;
    do_req(1'b1, 6'd0, 32'h11223344, 3'd2, 5'd10, 1'b0, d, e, r, lat, wc);
    tests++;
    if (e !== 1'b1 || lat !== 1 || wc !== 0 || d !== 32'h0) begin
      fails++; $display("FAIL illegal_store_t2: err=%b lat=%0d wcnt=%0d data=%h required 1 1 0 0", e, lat, wc, d);
    end
    do_req(1'b0, 6'd0, 32'h0, 3'd6, 5'd11, 1'b0, d, e, r, lat, wc);
    tests++;
    if (e !== 1'b1 || lat !== 1 || wc !== 0 || d !== 32'h0 || r !== 5'd11) begin
      fails++; $display("FAIL illegal_load_t6: err=%b lat=%0d wcnt=%0d data=%h rd=%0d required 1 1 0 0 11", e, lat, wc, d, r);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d; logic e; logic [4:0] r; int lat, wc;
    @(negedge clk);
    rspReady = 1'b1;
    reqWrite = 1'b1; reqAddr = 6'd12; reqData = 32'hDEADBEEF; reqType = 3'd0; reqRd = 5'd21;
    reqValid = 1'b1;
    @(posedge clk);
    #2;
    reqValid = 1'b0;
    tests++;
    if (memWrite !== 1'b1) begin
      fails++; $display("FAIL midwrite_active: memWrite=%b required 1", memWrite);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if (memWrite !== 1'b0 || reqReady !== 1'b0) begin
      fails++; $display("FAIL midwrite_async_drop: memWrite=%b reqReady=%b required 0 0", memWrite, reqReady);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    tests++;
    if ({memWrite, memAddr, memDataIn, memType, rspValid, rspData, rspRd, rspError} !== '0 || reqReady !== 1'b1) begin
      fails++;
      $display("FAIL midwrite_post_reset: memWrite=%b memAddr=%h memDataIn=%h rspValid=%b rspRd=%h reqReady=%b required all 0 and reqReady 1",
               memWrite, memAddr, memDataIn, rspValid, rspRd, reqReady);
    end
    @(negedge clk);
    tests++;
    if (rspValid !== 1'b0) begin
      fails++; $display("FAIL midwrite_rsp_discarded: rspValid=%b required 0", rspValid);
    end
    do_req(1'b0, 6'd12, 32'h0, 3'd0, 5'd22, 1'b0, d, e, r, lat, wc);
    tests++;
    if (d !== ref_load(12, 0) || e !== 1'b0) begin
      fails++; $display("FAIL midwrite_no_store: data=%h err=%b required %h 0", d, e, ref_load(12, 0));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic e; logic [4:0] r; int lat, wc;
    logic [31:0] exp_d;
    exp_d = ref_load(4, 1);
    do_req(1'b0, 6'd4, 32'h0, 3'd1, 5'd7, 1'b1, d, e, r, lat, wc);
    tests++;
    if (d !== exp_d || r !== 5'd7 || lat !== 3) begin
      fails++; $display("FAIL bp_first: data=%h rd=%0d lat=%0d required %h 7 3", d, r, lat, exp_d);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (rspValid !== 1'b1 || rspData !== exp_d || rspRd !== 5'd7 || rspError !== 1'b0 || reqReady !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_cycle%0d: rspValid=%b rspData=%h rspRd=%0d reqReady=%b required 1 %h 7 0",
                 c, rspValid, rspData, rspRd, reqReady, exp_d);
      end
    end
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
      fails++; $display("FAIL bp_release_idle: reqReady=%b rspValid=%b required 1 0", reqReady, rspValid);
    end
    do_req(1'b0, 6'd8, 32'h0, 3'd4, 5'd30, 1'b0, d, e, r, lat, wc);
    tests++;
    if (d !== ref_load(8, 4) || r !== 5'd30 || lat !== 3) begin
      fails++; $display("FAIL bp_next_req: data=%h rd=%0d lat=%0d required %h 30 3", d, r, lat, ref_load(8, 4));
    end
  endtask

  task automatic test_back_to_back();
    int idx [$];
    int guard;
    @(negedge clk);
    rspReady = 1'b1;
    reqWrite = 1'b0; reqAddr = 6'd0; reqType = 3'd0; reqRd = 5'd1; reqData = '0;
    reqValid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (reqReady === 1'b1) idx.push_back(c);
    end
    reqValid = 1'b0;
    tests++;
    if (idx.size() < 3) begin
      fails++; $display("FAIL b2b_accepts: got %0d ready cycles required at least 3", idx.size());
    end
    for (int i = 1; i < idx.size(); i++) begin
      tests++;
      if (idx[i] - idx[i-1] !== 4) begin
        fails++; $display("FAIL b2b_spacing%0d: got %0d cycles required 4", i, idx[i] - idx[i-1]);
      end
    end
    guard = 0;
    while (reqReady !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (reqReady !== 1'b1) begin
      fails++; $display("FAIL b2b_drain: reqReady=%b required 1", reqReady);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] d; logic e; logic [4:0] r; int lat, wc;
    bit w; int a, t; logic [31:0] wd; logic [4:0] rd;
    bit xe; logic [31:0] xd;
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom);
      a  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 35)) : int'($urandom_range(36, 63));
      t  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      wd = $urandom;
      rd = 5'($urandom);
      xe = ref_err(w, a, t);
      xd = (xe || w) ? 32'h0 : ref_load(a, t);
      do_req(w, 6'(a), wd, 3'(t), rd, 1'b0, d, e, r, lat, wc);
      if (!xe && w) ref_store(a, wd, t);
      tests++;
      if (e !== xe || d !== xd || r !== rd) begin
        fails++;
        $display("FAIL rand%0d_rsp: w=%0d a=%0d t=%0d got err=%b data=%h rd=%0d required %b %h %0d",
                 n, w, a, t, e, d, r, xe, xd, rd);
      end
      tests++;
      if (lat !== ref_lat(xe, w) || wc !== ((!xe && w) ? 1 : 0)) begin
        fails++;
        $display("FAIL rand%0d_timing: w=%0d a=%0d t=%0d got lat=%0d wcnt=%0d required %0d %0d",
                 n, w, a, t, lat, wc, ref_lat(xe, w), (!xe && w) ? 1 : 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rmem[i] = (i * 37 + 11) & 255;
    test_reset();
    test_word_store_load();
    test_extension();
    test_bounds();
    test_illegal_types();
    test_reset_mid_write();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller sitting directly upstream of the byte-addressed data memory. It accepts one load/store request at a time from the execute stage over a valid/ready handshake, bounds-checks it, and drives the memory's write, address, data and type inputs. For loads it captures the memory's registered read data, then applies the sign or zero extension the memory does not perform. It returns a result to writeback over a second valid/ready handshake.

## Interface
- MEM_BYTES, 32: implemented memory size in bytes; any access touching a byte at or above this address is an error.
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous, active-low reset.
- reqValid  input  1  request present.
- reqReady  output  1  unit can accept a request.
- reqWrite  input  1  1 = store, 0 = load.
- reqAddr  input  6  byte address.
- reqData  input  32  store data (low bytes used for byte/halfword).
- reqType  input  3  0 word, 1 halfword, 2 halfword-unsigned, 3 byte, 4 byte-unsigned; 5–7 illegal.
- reqRd  input  5  destination register tag, returned unchanged.
- memWrite  output  1  memory write strobe.
- memAddr  output  6  memory address.
- memDataIn  output  32  memory write data.
- memType  output  3  memory access type; only codes 0, 1 and 3 are ever driven.
- memDataOut  input  32  memory read data, registered inside the memory.
- rspValid  output  1  response present.
- rspReady  input  1  writeback accepts the response.
- rspData  output  32  extended load data; 0 for stores and errors.
- rspRd  output  5  tag of the request.
- rspError  output  1  request was illegal or out of bounds; no memory write was performed.

## Operation
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE: reqReady=1. On reqValid&reqReady, latch all request fields, then classify the request:
  - illegal type, or a store with type 2 or 4 -> error;
  - addr + size − 1 ≥ MEM_BYTES, with size 4/2/1 and the sum computed at 7-bit width -> error;
  - error -> RESP with rspError=1;
  - legal store -> WRITE;
  - legal load -> READ.
- Type mapping to memType: 0→0; 1 and 2→1; 3 and 4→3.
- READ: memAddr/memType held and memWrite=0; the memory samples the read on this cycle's closing edge. Next state is CAPTURE.
- CAPTURE: memDataOut is valid. Register the extended value into rspData as follows, then go to RESP:
  - type 0: passed through unchanged;
  - type 1: bits 15:0 sign-extended;
  - type 2: bits 15:0 zero-extended;
  - type 3: bits 7:0 sign-extended;
  - type 4: bits 7:0 zero-extended.
- WRITE: memWrite=1 for exactly this one cycle, with memAddr, memType and memDataIn=reqData. Next state is RESP.
- RESP: rspValid=1. rspData, rspRd and rspError are stable until rspReady. When rspValid&rspReady, go to IDLE.
- memWrite is 1 only in WRITE. In every other state memType=0 and memWrite=0, so the memory performs harmless word reads.
- Error requests never assert memWrite.

## Timing
- Reset (rstn low, asynchronous): state=IDLE; memWrite, memAddr, memDataIn, memType, rspValid, rspData, rspRd, rspError all 0; reqReady forced 0 while rstn=0.
- Reset mid-operation: an in-flight WRITE is aborted immediately (memWrite falls asynchronously), and the pending response is discarded.
- Load latency: accept at edge 0; READ during cycle 1; CAPTURE during cycle 2; rspValid from cycle 3.
- Store latency: accept at edge 0; WRITE during cycle 1; rspValid from cycle 2.
- Error latency: rspValid from cycle 1.
- Throughput: there is no overlap. reqReady=0 from acceptance until the cycle after the response handshake. The earliest next accept is therefore the cycle after rspValid&rspReady (back-to-back load: 4 cycles per request with rspReady=1).
- Back-pressure: rspReady low holds RESP indefinitely, with all rsp outputs unchanged.
- Request fields may change freely after acceptance; the unit uses only its latched copies.

## Test plan
- Reset: assert rstn=0 mid-WRITE -> memWrite drops to 0 without a clock edge; after release all outputs are 0 and reqReady=1.
- Word store then load: store 0x8899AABB to addr 4, type 0 -> memWrite high exactly one cycle, rspError=0. Then load addr 4, type 0 -> rspData=0x8899AABB, rspValid on cycle 3.
- Extension, with memory byte 8 holding 0x80 and byte 9 holding 0xF0:
  - type 1 at addr 8 -> 0xFFFFF080;
  - type 2 at addr 8 -> 0x0000F080;
  - type 3 at addr 8 -> 0xFFFFFF80;
  - type 4 at addr 8 -> 0x00000080.
- Bounds:
  - word load at addr 28 -> legal;
  - word at addr 29 -> rspError=1, rspData=0, memWrite never 1;
  - halfword store at addr 31 -> error;
  - byte at addr 31 -> legal;
  - addr 40 byte -> error.
- Illegal types: store with type 2, and load with type 6 -> rspError=1, response on cycle 1, memWrite stays 0.
- Back-pressure: hold rspReady=0 for 5 cycles after a load response -> rspValid, rspData and rspRd stable, reqReady=0 throughout. Raise rspReady -> IDLE next cycle, and a new request is accepted.
